// File: rtl/picorv32_pcpi_share_arb.sv
// Two-to-one PCPI arbiter in front of a single shared coprocessor.
// Only MUL/DIV-group instructions are forwarded. A round-robin pointer breaks
// ties. The losing requester is held off with wait, and the winner receives a
// one-cycle ready pulse carrying the coprocessor result.
module picorv32_pcpi_share_arb #(
  parameter logic [31:0] MATCH_MASK     = 32'hfe00007f,
  parameter logic [31:0] MATCH_VALUE    = 32'h02000033,
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [31:0] req0_insn,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  output logic        req0_wr,
  output logic [31:0] req0_rd,
  output logic        req0_wait,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_insn,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  output logic        req1_wr,
  output logic [31:0] req1_rd,
  output logic        req1_wait,
  output logic        req1_ready,
  output logic        co_valid,
  output logic [31:0] co_insn,
  output logic [31:0] co_rs1,
  output logic [31:0] co_rs2,
  input  logic        co_wr,
  input  logic [31:0] co_rd,
  input  logic        co_wait,
  input  logic        co_ready
);

  // state | meaning
  // IDLE  | no op in flight; pick a winner among eligible requesters
  // BUSY  | operands presented to the coprocessor, waiting for co_ready
  // RESP  | one-cycle ready pulse to the granted requester
  // FLUSH | granted requester aborted; drain the coprocessor and discard the result
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP, ST_FLUSH} state_t;

  // Timeout is a down-counter reloaded with TIMEOUT_CYCLES-1. Reaching zero
  // while co_wait is low releases the slot.
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  state_t           state;
  logic             grant;
  logic             prio;
  logic [TMR_W-1:0] tmr;
  logic             elig0;
  logic             elig1;
  logic             win;
  logic             grant_valid;

  assign elig0       = req0_valid && ((req0_insn & MATCH_MASK) == MATCH_VALUE);
  assign elig1       = req1_valid && ((req1_insn & MATCH_MASK) == MATCH_VALUE);
  assign win         = (elig0 && elig1) ? prio : elig1;
  assign grant_valid = grant ? req1_valid : req0_valid;

  // Hold-off: every eligible requester waits except the one being answered.
  // The wait is gated by resetn so that all outputs stay quiet while reset is held.
  assign req0_wait = resetn && elig0 && !(state == ST_RESP && !grant);
  assign req1_wait = resetn && elig1 && !(state == ST_RESP &&  grant);

  // Arbitration FSM with registered coprocessor and response outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      prio       <= 1'b0;
      tmr        <= '0;
      co_valid   <= 1'b0;
      co_insn    <= '0;
      co_rs1     <= '0;
      co_rs2     <= '0;
      req0_ready <= 1'b0;
      req0_wr    <= 1'b0;
      req0_rd    <= '0;
      req1_ready <= 1'b0;
      req1_wr    <= 1'b0;
      req1_rd    <= '0;
    end else begin
      req0_ready <= 1'b0;
      req0_wr    <= 1'b0;
      req0_rd    <= '0;
      req1_ready <= 1'b0;
      req1_wr    <= 1'b0;
      req1_rd    <= '0;
      case (state)
        ST_IDLE: begin
          if (elig0 || elig1) begin
            state    <= ST_BUSY;
            grant    <= win;
            co_valid <= 1'b1;
            co_insn  <= win ? req1_insn : req0_insn;
            co_rs1   <= win ? req1_rs1  : req0_rs1;
            co_rs2   <= win ? req1_rs2  : req0_rs2;
            tmr      <= TMR_LOAD;
          end
        end
        ST_BUSY: begin
          if (co_ready) begin
            state    <= ST_RESP;
            co_valid <= 1'b0;
            if (grant) begin
              req1_ready <= 1'b1;
              req1_wr    <= co_wr;
              req1_rd    <= co_rd;
            end else begin
              req0_ready <= 1'b1;
              req0_wr    <= co_wr;
              req0_rd    <= co_rd;
            end
          end else if (!grant_valid) begin
            state    <= ST_FLUSH;
            co_valid <= 1'b0;
            tmr      <= TMR_LOAD;
          end else if (co_wait) begin
            tmr <= TMR_LOAD;
          end else if (tmr == '0) begin
            state    <= ST_IDLE;
            co_valid <= 1'b0;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end
        ST_RESP: begin
          prio  <= ~grant;
          state <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (co_ready || (!co_wait && tmr == '0)) begin
            prio  <= ~grant;
            state <= ST_IDLE;
          end else if (co_wait) begin
            tmr <= TMR_LOAD;
          end else begin
            tmr <= tmr - TMR_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          co_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_pcpi_share_arb.sv
// Bench for picorv32_pcpi_share_arb: directed scenarios plus randomized traffic.
// A per-port scoreboard and a round-robin reference model are checked by a monitor.
module tb_picorv32_pcpi_share_arb;
  localparam logic [31:0] MASK  = 32'hfe00007f;
  localparam logic [31:0] VALUE = 32'h02000033;
  localparam int          TMO   = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_insn, req0_rs1, req0_rs2, req1_insn, req1_rs1, req1_rs2;
  logic        req0_wr, req0_wait, req0_ready, req1_wr, req1_wait, req1_ready;
  logic [31:0] req0_rd, req1_rd;
  logic        co_valid, co_wr, co_wait, co_ready;
  logic [31:0] co_insn, co_rs1, co_rs2, co_rd;

  picorv32_pcpi_share_arb dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_insn(req0_insn), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_wait(req0_wait), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_insn(req1_insn), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_wait(req1_wait), .req1_ready(req1_ready),
    .co_valid(co_valid), .co_insn(co_insn), .co_rs1(co_rs1), .co_rs2(co_rs2),
    .co_wr(co_wr), .co_rd(co_rd), .co_wait(co_wait), .co_ready(co_ready)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic [32:0] exp_q0[$];
  logic [32:0] exp_q1[$];
  logic        mdl_prio = 1'b0;
  logic        mdl_grant = 1'b0;
  logic        cop_on = 1'b1;
  logic        cop_rand = 1'b0;
  int          cop_lat = 2;
  logic        cop_active = 1'b0;
  int          cop_cnt = 0;
  logic [32:0] cop_res = '0;

  function automatic logic eligible(input logic v, input logic [31:0] insn);
    return v && ((insn & MASK) == VALUE);
  endfunction

  // Result the coprocessor model produces: {wr, rd}. rd = rs1*rs2 + funct3, wr = ~rs2[0]
  function automatic logic [32:0] ref_result(input logic [31:0] insn, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] prod;
    prod = a * b;
    return {~b[0], prod + {29'b0, insn[14:12]}};
  endfunction

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    check(act === req, name, act, req);
  endtask

  task automatic set_req(input int p, input logic v, input logic [31:0] insn,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_insn = insn; req0_rs1 = a; req0_rs2 = b;
    end else begin
      req1_valid = v; req1_insn = insn; req1_rs1 = a; req1_rs2 = b;
    end
  endtask

  // One PCPI transaction from requester p; eligible ops are held until ready.
  task automatic req_op(input int p, input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b);
    bit got;
    @(posedge clk); #1;
    set_req(p, 1'b1, insn, a, b);
    if (eligible(1'b1, insn)) begin
      if (p == 0) exp_q0.push_back(ref_result(insn, a, b));
      else        exp_q1.push_back(ref_result(insn, a, b));
      got = 0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        got = (p == 0) ? req0_ready : req1_ready;
      end
      check(got, "ready_within_bound", got, 1);
    end else begin
      repeat (3) @(negedge clk);
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, '0, '0, '0);
  endtask

  task automatic rand_requester(input int p, input int nops);
    logic [31:0] insn;
    for (int k = 0; k < nops; k++) begin
      if ($urandom_range(0, 9) < 8) insn = ($urandom & ~MASK) | VALUE;
      else begin
        insn = $urandom;
        if ((insn & MASK) == VALUE) insn = insn ^ 32'h1;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      req_op(p, insn, $urandom, $urandom);
    end
  endtask

  // Coprocessor model: once started it always completes, even if valid drops.
  task automatic cop_model();
    forever begin
      @(posedge clk); #1;
      co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
      if (!cop_active && co_valid && cop_on) begin
        cop_active = 1'b1;
        cop_cnt = 0;
        cop_res = ref_result(co_insn, co_rs1, co_rs2);
        if (cop_rand) cop_lat = $urandom_range(0, 5);
      end
      if (cop_active) begin
        if (cop_cnt >= cop_lat) begin
          co_ready = 1'b1;
          {co_wr, co_rd} = cop_res;
          cop_active = 1'b0;
        end else cop_cnt++;
      end
    end
  endtask

  task automatic port_check(input int p, input logic e, input logic wt, input logic rdy,
                            input logic wr, input logic [31:0] rd, input logic prdy);
    logic [32:0] exp;
    if (!rdy) check(!wr && rd == '0, "rd_wr_zero_without_ready", {wr, rd}, 0);
    else begin
      check_eq("ready_on_granted_port", p, mdl_grant);
      check(!prdy, "ready_single_cycle", prdy, 0);
      if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0))
        check(0, "ready_unexpected", p, 2);
      else begin
        exp = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq("result_wr_rd", {wr, rd}, exp);
      end
      mdl_prio = (p == 0) ? 1'b1 : 1'b0;
    end
    if (e) check(wt != rdy, "eligible_wait_xor_ready", {wt, rdy}, rdy ? 2'b01 : 2'b10);
    else   check(!wt && !rdy, "ineligible_quiet", {wt, rdy}, 0);
  endtask

  // Monitor: checks the winner at every issue edge and each port's outputs every cycle.
  task automatic monitor();
    logic p_cov = 1'b0, p_e0 = 1'b0, p_e1 = 1'b0, p_r0 = 1'b0, p_r1 = 1'b0;
    logic [31:0] p_i0 = '0, p_a0 = '0, p_b0 = '0, p_i1 = '0, p_a1 = '0, p_b1 = '0;
    logic e0, e1, w;
    forever begin
      @(negedge clk);
      e0 = eligible(req0_valid, req0_insn);
      e1 = eligible(req1_valid, req1_insn);
      if (resetn) begin
        if (co_valid && !p_cov) begin
          if (!p_e0 && !p_e1) check(0, "issue_without_request", 1, 0);
          else begin
            w = (p_e0 && p_e1) ? mdl_prio : p_e1;
            check_eq("issue_insn", co_insn, w ? p_i1 : p_i0);
            check_eq("issue_rs1", co_rs1, w ? p_a1 : p_a0);
            check_eq("issue_rs2", co_rs2, w ? p_b1 : p_b0);
            mdl_grant = w;
          end
        end
        port_check(0, e0, req0_wait, req0_ready, req0_wr, req0_rd, p_r0);
        port_check(1, e1, req1_wait, req1_ready, req1_wr, req1_rd, p_r1);
      end
      p_cov = co_valid; p_e0 = e0; p_e1 = e1; p_r0 = req0_ready; p_r1 = req1_ready;
      p_i0 = req0_insn; p_a0 = req0_rs1; p_b0 = req0_rs2;
      p_i1 = req1_insn; p_a1 = req1_rs1; p_b1 = req1_rs2;
    end
  endtask

  task automatic run_timeout(input int stretch_at, input int expect_n);
    int n;
    bit got;
    @(posedge clk); #1;
    set_req(0, 1'b1, VALUE, 32'd11, 32'd13);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = co_valid;
    end
    check(got, "t5_issue", got, 1);
    n = got ? 1 : 0;
    while (got && n < expect_n) begin
      @(posedge clk); #1;
      co_wait = (n == stretch_at);
      @(negedge clk);
      if (!co_valid) got = 0;
      else n++;
    end
    @(posedge clk); #1;
    co_wait = 1'b0;
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check_eq("t5_busy_cycles", n, expect_n);
    check_eq("t5_released", co_valid, 0);
    check_eq("t5_wait_falls", req0_wait, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_co_valid"}, co_valid, 0);
    check_eq({tag, "_co_ops"}, {co_insn, co_rs1}, 0);
    check_eq({tag, "_co_rs2"}, co_rs2, 0);
    check_eq({tag, "_req0_out"}, {req0_wait, req0_ready, req0_wr, req0_rd}, 0);
    check_eq({tag, "_req1_out"}, {req1_wait, req1_ready, req1_wr, req1_rd}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    co_wait = 1'b0; co_ready = 1'b0; co_wr = 1'b0; co_rd = '0;
    fork
      monitor();
      cop_model();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1;

    // T1: single MUL 7*6, coprocessor answers two cycles after valid rises
    cop_rand = 1'b0; cop_lat = 2;
    fork
      req_op(0, VALUE, 32'd7, 32'd6);
      begin
        @(posedge clk); #2;
        @(negedge clk); check_eq("t1_issue_latency_idle", co_valid, 0);
        @(negedge clk); check_eq("t1_issue_latency_busy", co_valid, 1);
        @(posedge clk); #2;
        req0_rs1 = 32'd99;
        @(negedge clk); check_eq("t1_not_ready_b2", req0_ready, 0);
        @(negedge clk); check_eq("t1_not_ready_b3", req0_ready, 0);
        @(negedge clk); check_eq("t1_ready", req0_ready, 1);
        check_eq("t1_rd", req0_rd, 42);
        check_eq("t1_wr", req0_wr, 1);
        @(negedge clk); check_eq("t1_ready_drop", req0_ready, 0);
      end
    join

    // T2: contention, two back-to-back ties
    cop_rand = 1'b1;
    repeat (2) begin
      fork
        req_op(0, VALUE | 32'h0000_1000, $urandom, $urandom);
        req_op(1, VALUE | 32'h0000_4000, $urandom, $urandom);
      join
    end

    // T3: ADD is not eligible
    @(posedge clk); #1;
    set_req(1, 1'b1, 32'h0000_0033, 32'd1, 32'd2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t3_no_issue", {co_valid, req1_wait, req1_ready}, 0);
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, '0, '0, '0);

    // T4: abort one cycle into BUSY; the late result is discarded
    cop_rand = 1'b0; cop_lat = 3;
    @(posedge clk); #1;
    set_req(0, 1'b1, VALUE, 32'd3, 32'd5);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = co_valid;
    end
    check(got, "t4_issue", got, 1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk); check_eq("t4_flush_valid_low", co_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); check_eq("t4_no_ready", req0_ready, 0);
    end
    mdl_prio = 1'b1;
    cop_rand = 1'b1;
    fork
      req_op(0, VALUE, $urandom, $urandom);
      req_op(1, VALUE, $urandom, $urandom);
    join

    // T5: timeout release, then a co_wait stretch that restarts the count
    cop_on = 1'b0;
    run_timeout(0, TMO);
    run_timeout(20, TMO + 21);

    // T6: asynchronous reset mid-BUSY between clock edges
    @(posedge clk); #1;
    set_req(0, 1'b1, VALUE, 32'd21, 32'd22);
    set_req(1, 1'b1, VALUE, 32'd23, 32'd24);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = co_valid;
    end
    check(got, "t6_issue", got, 1);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(posedge clk); #1;
    set_req(0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, '0, '0, '0);
    @(negedge clk); #2;
    resetn = 1'b1;
    mdl_prio = 1'b0;
    cop_on = 1'b1;
    fork
      req_op(0, VALUE, $urandom, $urandom);
      req_op(1, VALUE, $urandom, $urandom);
    join

    // Randomized traffic on both ports
    fork
      rand_requester(0, 40);
      rand_requester(1, 40);
    join
    repeat (5) @(negedge clk);
    check_eq("scoreboard_drained", {exp_q0.size(), exp_q1.size()}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
